// File: rtl/alu_dispatch.sv
// Sequencing stage ahead of the ALU: 8-entry register file, one command per 4 cycles.
// Optional flags register is built when ALU_DISPATCH_FLAGS_EN is defined.
`ifndef ALU_DISPATCH_B_WIDTH
`define ALU_DISPATCH_B_WIDTH 16
`endif

module alu_dispatch #(
   parameter int B_WIDTH = `ALU_DISPATCH_B_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [3:0]         cmd_op,
   input  logic [2:0]         cmd_ra,
   input  logic [2:0]         cmd_rb,
   input  logic [2:0]         cmd_rd,
   input  logic               ld_en,
   input  logic [2:0]         ld_addr,
   input  logic [B_WIDTH-1:0] ld_data,
   input  logic [2:0]         dbg_addr,
   output logic [B_WIDTH-1:0] dbg_data,
   output logic [B_WIDTH-1:0] alu_ha,
   output logic [B_WIDTH-1:0] alu_la,
   output logic [B_WIDTH-1:0] alu_hb,
   output logic [B_WIDTH-1:0] alu_lb,
   output logic [3:0]         alu_op,
   input  logic [B_WIDTH-1:0] alu_lc,
   input  logic [B_WIDTH-1:0] alu_hc,
   input  logic               alu_zr,
   input  logic               alu_ng,
   input  logic               alu_carry,
   output logic               done,
   output logic               flag_zr,
   output logic               flag_ng,
   output logic               flag_carry
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_WB} state_t;

   state_t               state_q, state_d;
   logic [3:0]           op_q;
   logic [2:0]           ra_q, rb_q, rd_q;
   logic [B_WIDTH-1:0]   ha_q, la_q, hb_q, lb_q;
   logic [3:0]           aop_q;
   logic [B_WIDTH-1:0]   lc_q, hc_q;
   logic                 done_q;
   logic [B_WIDTH-1:0]   regs_q [8];

   logic                 dbl_s;
   logic [2:0]           a_lo_s, a_hi_s, b_lo_s, b_hi_s, d_lo_s, d_hi_s;

   // Double ops drop bit 0 of every index and use the even/odd register pair.
   always_comb begin
      dbl_s  = op_q[3];
      a_hi_s = {ra_q[2:1], 1'b1};
      b_hi_s = {rb_q[2:1], 1'b1};
      d_hi_s = {rd_q[2:1], 1'b1};
      if (dbl_s) begin
         a_lo_s = {ra_q[2:1], 1'b0};
         b_lo_s = {rb_q[2:1], 1'b0};
         d_lo_s = {rd_q[2:1], 1'b0};
      end else begin
         a_lo_s = ra_q;
         b_lo_s = rb_q;
         d_lo_s = rd_q;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: state_d = S_EXEC;
         S_EXEC:  state_d = S_WB;
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= 4'd0;
         ra_q    <= 3'd0;
         rb_q    <= 3'd0;
         rd_q    <= 3'd0;
         ha_q    <= '0;
         la_q    <= '0;
         hb_q    <= '0;
         lb_q    <= '0;
         aop_q   <= 4'd0;
         lc_q    <= '0;
         hc_q    <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == S_EXEC);
         if (state_q == S_IDLE && cmd_valid) begin
            op_q <= cmd_op;
            ra_q <= cmd_ra;
            rb_q <= cmd_rb;
            rd_q <= cmd_rd;
         end
         if (state_q == S_FETCH) begin
            la_q  <= regs_q[a_lo_s];
            lb_q  <= regs_q[b_lo_s];
            ha_q  <= dbl_s ? regs_q[a_hi_s] : '0;
            hb_q  <= dbl_s ? regs_q[b_hi_s] : '0;
            aop_q <= op_q;
         end
         if (state_q == S_EXEC) begin
            lc_q <= alu_lc;
            hc_q <= alu_hc;
         end
         // Loads only in IDLE and writeback only in WB, so the two never collide.
         if (state_q == S_IDLE && ld_en) begin
            regs_q[ld_addr] <= ld_data;
         end else if (state_q == S_WB) begin
            regs_q[d_lo_s] <= lc_q;
            if (dbl_s) begin
               regs_q[d_hi_s] <= hc_q;
            end
         end
      end
   end

`ifdef ALU_DISPATCH_FLAGS_EN
   logic zr_q, ng_q, cy_q;
   logic fzr_q, fng_q, fcy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         zr_q  <= 1'b0;
         ng_q  <= 1'b0;
         cy_q  <= 1'b0;
         fzr_q <= 1'b0;
         fng_q <= 1'b0;
         fcy_q <= 1'b0;
      end else begin
         if (state_q == S_EXEC) begin
            zr_q <= alu_zr;
            ng_q <= alu_ng;
            cy_q <= alu_carry;
         end
         if (state_q == S_WB) begin
            fzr_q <= zr_q;
            fng_q <= ng_q;
            fcy_q <= cy_q;
         end
      end
   end

   assign flag_zr    = fzr_q;
   assign flag_ng    = fng_q;
   assign flag_carry = fcy_q;
`else
   logic unused_flags_s;
   assign unused_flags_s = alu_zr ^ alu_ng ^ alu_carry;
   assign flag_zr    = 1'b0;
   assign flag_ng    = 1'b0;
   assign flag_carry = 1'b0;
`endif

   assign cmd_ready = (state_q == S_IDLE) && !rst;
   assign dbg_data  = regs_q[dbg_addr];
   assign alu_ha    = ha_q;
   assign alu_la    = la_q;
   assign alu_hb    = hb_q;
   assign alu_lb    = lb_q;
   assign alu_op    = aop_q;
   assign done      = done_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with an adder model standing in for the ALU.
// Flag expectations follow ALU_DISPATCH_FLAGS_EN.
module tb_alu_dispatch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_op = 4'd0;
   logic [2:0]  cmd_ra = 3'd0, cmd_rb = 3'd0, cmd_rd = 3'd0;
   logic        ld_en = 1'b0;
   logic [2:0]  ld_addr = 3'd0;
   logic [15:0] ld_data = 16'd0;
   logic [2:0]  dbg_addr = 3'd0;
   logic [15:0] dbg_data;
   logic [15:0] alu_ha, alu_la, alu_hb, alu_lb;
   logic [3:0]  alu_op;
   logic [15:0] alu_lc, alu_hc;
   logic        alu_zr, alu_ng, alu_carry;
   logic        done, flag_zr, flag_ng, flag_carry;

   int n_cmp = 0;
   int n_err = 0;

   alu_dispatch dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .alu_ha(alu_ha), .alu_la(alu_la), .alu_hb(alu_hb), .alu_lb(alu_lb), .alu_op(alu_op),
      .alu_lc(alu_lc), .alu_hc(alu_hc), .alu_zr(alu_zr), .alu_ng(alu_ng), .alu_carry(alu_carry),
      .done(done), .flag_zr(flag_zr), .flag_ng(flag_ng), .flag_carry(flag_carry)
   );

   always #5 clk = ~clk;

   // Adder ALU; single ops drive a junk high word that must never be written back.
   logic [32:0] sum_d;
   logic [16:0] sum_s;
   always_comb begin
      sum_d = {1'b0, alu_ha, alu_la} + {1'b0, alu_hb, alu_lb};
      sum_s = {1'b0, alu_la} + {1'b0, alu_lb};
      if (alu_op[3]) begin
         alu_lc    = sum_d[15:0];
         alu_hc    = sum_d[31:16];
         alu_zr    = (sum_d[31:0] == 32'd0);
         alu_ng    = sum_d[31];
         alu_carry = sum_d[32];
      end else begin
         alu_lc    = sum_s[15:0];
         alu_hc    = 16'hDEAD;
         alu_zr    = (sum_s[15:0] == 16'd0);
         alu_ng    = sum_s[15];
         alu_carry = sum_s[16];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
      dbg_addr = a;
      #1;
      check_eq(tag, {16'd0, dbg_data}, {16'd0, exp});
   endtask

   task automatic chk_flags(input string tag, input logic zr, input logic ng, input logic cy);
`ifdef ALU_DISPATCH_FLAGS_EN
      check_eq(tag, {29'd0, flag_zr, flag_ng, flag_carry}, {29'd0, zr, ng, cy});
`else
      check_eq(tag, {29'd0, flag_zr, flag_ng, flag_carry}, {29'd0, 1'b0, 1'b0, 1'b0 & zr & ng & cy});
`endif
   endtask

   // Called at a negedge while IDLE; returns at a negedge while IDLE.
   task automatic do_load(input logic [2:0] a, input logic [15:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(posedge clk);
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   // Issues one command and checks the fixed 4-cycle handshake and done timing.
   task automatic run_cmd(input string tag, input logic [3:0] op, input logic [2:0] ra,
                          input logic [2:0] rb, input logic [2:0] rd);
      cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_valid = 1'b1;
      check_eq({tag, "_ready_idle"}, {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_eq({tag, "_fetch"}, {30'd0, cmd_ready, done}, 32'd0);
      @(negedge clk);
      check_eq({tag, "_exec"}, {30'd0, cmd_ready, done}, 32'd0);
      @(negedge clk);
      check_eq({tag, "_wb"}, {30'd0, cmd_ready, done}, 32'd1);
      @(negedge clk);
      check_eq({tag, "_back_idle"}, {30'd0, cmd_ready, done}, 32'd2);
   endtask

   initial begin
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_ready", {31'd0, cmd_ready}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_alu_a", {alu_ha, alu_la}, 32'd0);
      check_eq("rst_alu_b", {alu_hb, alu_lb}, 32'd0);
      check_eq("rst_alu_op", {28'd0, alu_op}, 32'd0);
      chk_flags("rst_flags", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         chk_reg($sformatf("rst_r%0d", i), 3'(i), 16'h0000);
      end
      rst = 1'b0;
      #1;
      check_eq("rst_release_ready", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);

      // single add
      do_load(3'd1, 16'h0003);
      do_load(3'd2, 16'h0005);
      run_cmd("add", 4'd1, 3'd1, 3'd2, 3'd3);
      check_eq("add_la_lb", {alu_la, alu_lb}, {16'h0003, 16'h0005});
      check_eq("add_ha_hb", {alu_ha, alu_hb}, 32'd0);
      chk_reg("add_r3", 3'd3, 16'h0008);
      chk_reg("add_r2_kept", 3'd2, 16'h0005);
      chk_flags("add_flags", 1'b0, 1'b0, 1'b0);

      // carry out with zero result
      do_load(3'd1, 16'hFFFF);
      do_load(3'd2, 16'h0001);
      run_cmd("cz", 4'd1, 3'd1, 3'd2, 3'd0);
      chk_reg("cz_r0", 3'd0, 16'h0000);
      chk_reg("cz_r1_kept", 3'd1, 16'hFFFF);
      chk_flags("cz_flags", 1'b1, 1'b0, 1'b1);

      // double add across the register pair
      do_load(3'd0, 16'hFFFF);
      do_load(3'd1, 16'h0001);
      do_load(3'd2, 16'h0001);
      do_load(3'd3, 16'h0000);
      run_cmd("dbl", 4'd9, 3'd0, 3'd2, 3'd5);
      check_eq("dbl_a", {alu_ha, alu_la}, 32'h0001_FFFF);
      check_eq("dbl_b", {alu_hb, alu_lb}, 32'h0000_0001);
      chk_reg("dbl_r4", 3'd4, 16'h0000);
      chk_reg("dbl_r5", 3'd5, 16'h0002);
      chk_flags("dbl_flags", 1'b0, 1'b0, 1'b0);

      // back-to-back commands with valid held: r6 = r5+r5 = 4, then r7 = r6+r6 = 8
      cmd_op = 4'd1; cmd_ra = 3'd5; cmd_rb = 3'd5; cmd_rd = 3'd6; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_ra = 3'd6; cmd_rb = 3'd6; cmd_rd = 3'd7;
      check_eq("bp_a_c1", {30'd0, cmd_ready, done}, 32'd0);
      @(negedge clk);
      check_eq("bp_a_c2", {30'd0, cmd_ready, done}, 32'd0);
      @(negedge clk);
      check_eq("bp_a_c3", {30'd0, cmd_ready, done}, 32'd1);
      @(negedge clk);
      check_eq("bp_b_accept", {30'd0, cmd_ready, done}, 32'd2);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_eq("bp_b_c1", {30'd0, cmd_ready, done}, 32'd0);
      @(negedge clk);
      check_eq("bp_b_c2", {30'd0, cmd_ready, done}, 32'd0);
      @(negedge clk);
      check_eq("bp_b_c3", {30'd0, cmd_ready, done}, 32'd1);
      @(negedge clk);
      check_eq("bp_idle", {30'd0, cmd_ready, done}, 32'd2);
      chk_reg("bp_r6", 3'd6, 16'h0004);
      chk_reg("bp_r7", 3'd7, 16'h0008);

      // load attempted during EXEC is dropped, then honoured in IDLE
      cmd_op = 4'd1; cmd_ra = 3'd1; cmd_rb = 3'd1; cmd_rd = 3'd7; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 3'd6; ld_data = 16'h1234;
      @(negedge clk);
      ld_en = 1'b0;
      check_eq("busy_done", {31'd0, done}, 32'd1);
      @(negedge clk);
      chk_reg("busy_r6", 3'd6, 16'h0004);
      chk_reg("busy_r7", 3'd7, 16'h0002);
      do_load(3'd6, 16'h1234);
      chk_reg("idle_r6", 3'd6, 16'h1234);

      // load and accept in the same cycle: FETCH sees the loaded value
      ld_en = 1'b1; ld_addr = 3'd2; ld_data = 16'h0007;
      cmd_op = 4'd1; cmd_ra = 3'd2; cmd_rb = 3'd2; cmd_rd = 3'd4; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ld_en = 1'b0; cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk_reg("ldcmd_r4", 3'd4, 16'h000E);

      // reset during EXEC aborts the command and clears everything
      do_load(3'd3, 16'h00AA);
      cmd_op = 4'd1; cmd_ra = 3'd1; cmd_rb = 3'd1; cmd_rd = 3'd3; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_done", {31'd0, done}, 32'd0);
      rst = 1'b0;
      #1;
      check_eq("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq($sformatf("mid_rst_no_done%0d", i), {30'd0, cmd_ready, done}, 32'd2);
      end
      chk_reg("mid_rst_r3", 3'd3, 16'h0000);
      chk_reg("mid_rst_r1", 3'd1, 16'h0000);
      check_eq("mid_rst_alu_a", {alu_ha, alu_la}, 32'd0);
      chk_flags("mid_rst_flags", 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
